// File: rtl/pwm_mixer.sv
`timescale 1ns / 1ps
// pwm_mixer: mixes CHANNELS unsigned samples into a single 1-bit audio stream, either as
// counter-compare PWM (MODE 0) or first-order sigma-delta (MODE 1).
// A single-entry shadow register decouples the sample handshake from the output period.
// A new level only becomes active at the period wrap, so every period plays one whole level.
module pwm_mixer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODE     = 0,
    localparam int unsigned SUMW    = WIDTH + $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      mute,
    output logic                      pwm,
    output logic [SUMW-1:0]           level_out,
    output logic                      period_start
);

    localparam int unsigned MAX     = CHANNELS * ((2 ** WIDTH) - 1);
    localparam int unsigned AccW    = SUMW + 1;
    localparam logic [SUMW-1:0] CntLast = SUMW'(MAX - 1);
    localparam logic [AccW-1:0] MaxAcc  = AccW'(MAX);

    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic                      full_q, full_d;
    logic [SUMW-1:0]           cnt_q, cnt_d;
    logic [SUMW-1:0]           level_q, level_d;
    logic [SUMW-1:0]           mix_sum;
    logic [AccW-1:0]           acc_q, acc_d;
    logic [AccW-1:0]           acc_sum;
    logic                      pwm_q, pwm_d;
    logic                      start_q, start_d;
    logic                      wrap;

    // Unsigned sum of all shadow channels; SUMW bits cannot overflow.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_sum = mix_sum + SUMW'(shadow_q[i*WIDTH +: WIDTH]);
        end
    end

    // Next state: period counter, modulator, level swap at wrap, and sample capture.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pwm_d    = pwm_q;
        level_d  = level_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        start_d  = 1'b0;
        acc_sum  = acc_q + {1'b0, level_q};
        wrap     = ena && (cnt_q == CntLast);

        if (ena) begin
            cnt_d = wrap ? '0 : cnt_q + SUMW'(1);
            if (MODE == 0) begin
                pwm_d = (cnt_q < level_q);
            end else if (acc_sum >= MaxAcc) begin
                acc_d = acc_sum - MaxAcc;
                pwm_d = 1'b1;
            end else begin
                acc_d = acc_sum;
                pwm_d = 1'b0;
            end
            // Mute only gates the output; the modulator keeps running underneath.
            if (mute) begin
                pwm_d = 1'b0;
            end
        end

        if (wrap && full_q) begin
            level_d = mix_sum;
            full_d  = 1'b0;
            start_d = 1'b1;
        end

        // Capture needs an empty shadow, so it can never collide with a level swap;
        // a capture on an empty-shadow wrap simply waits for the following wrap.
        if (sample_valid && !full_q) begin
            shadow_d = sample_in;
            full_d   = 1'b1;
        end
    end

    // State registers with synchronous active-low reset; reset discards any offered sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            full_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            level_q  <= '0;
            pwm_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            full_q   <= full_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            level_q  <= level_d;
            pwm_q    <= pwm_d;
            start_q  <= start_d;
        end
    end

    assign sample_ready = !full_q;
    assign pwm          = pwm_q;
    assign level_out    = level_q;
    assign period_start = start_q;

endmodule
